// File: rtl/axis_byte_compactor.sv
// ----------------------------------------------------------------------------
// axis_byte_compactor
//
// Purpose:
//   Takes AXI4-Stream beats with arbitrary (sparse) tkeep and produces dense,
//   full-width beats. Kept bytes keep their order and packet (tlast)
//   boundaries are preserved. The byte count of each completed packet is
//   reported once that packet's last output beat has been accepted.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   s_tdata    input data, byte i = s_tdata[8i+:8]
//   s_tkeep    input byte enables, any pattern (all-zero allowed)
//   s_tlast    last beat of input packet
//   s_tvalid   input valid
//   s_tready   input ready (held low during reset)
//   m_tdata    compacted output data
//   m_tkeep    output byte enables, always contiguous from bit 0
//   m_tlast    last beat of output packet
//   m_tvalid   output valid
//   m_tready   output ready
//   pkt_bytes  byte count of the packet just completed
//   pkt_done   one-cycle pulse, pkt_bytes valid
//
// Pipeline:
//   stage1  : the accepted beat, already squeezed so its kept bytes sit in
//             lanes 0..n-1 (lanes >= n are zero).
//   residue : f (0..63) bytes left over from earlier beats of the packet.
//   output  : the beat presented on m_*.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   ACCUM  | normal operation; stage1 merges into residue/output
//   FLUSH  | last beat overflowed one output beat; residue still owes the
//          | tlast beat, stage1 is held until it has been loaded
// ----------------------------------------------------------------------------
module axis_byte_compactor #(
    parameter int DATA_BITS = 512,
    parameter int LEN_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [LEN_BITS-1:0]    pkt_bytes,
    output logic                   pkt_done
);

    localparam int BYTES = DATA_BITS / 8;
    localparam int CW    = $clog2(BYTES + 1);   // holds 0..BYTES
    localparam int FW    = $clog2(BYTES);       // holds 0..BYTES-1

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    // Mask with the low k bits set.
    function automatic logic [BYTES-1:0] lo_mask(input logic [CW-1:0] k);
        logic [BYTES-1:0] m;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  s1_full_q,  s1_full_d;
    logic [DATA_BITS-1:0]  s1_data_q,  s1_data_d;
    logic [CW-1:0]         s1_n_q,     s1_n_d;
    logic                  s1_last_q,  s1_last_d;

    logic [DATA_BITS-1:0]  res_q,      res_d;
    logic [FW-1:0]         f_q,        f_d;
    logic [0:0]            state_q,    state_d;

    logic [DATA_BITS-1:0]  m_data_q,   m_data_d;
    logic [BYTES-1:0]      m_keep_q,   m_keep_d;
    logic                  m_last_q,   m_last_d;
    logic                  m_valid_q,  m_valid_d;

    logic [LEN_BITS-1:0]   cnt_q,      cnt_d;
    logic [LEN_BITS-1:0]   plen_q,     plen_d;
    logic [LEN_BITS-1:0]   pbytes_q,   pbytes_d;
    logic                  pdone_q,    pdone_d;

    // ------------------------------------------------------------------
    // Input compaction: j-th set keep bit lands in lane j
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]  comp_data;
    logic [CW-1:0]         comp_n;

    always_comb begin
        comp_data = '0;
        comp_n    = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (s_tkeep[i]) begin
                // comp_n < BYTES whenever a write happens, so the low bits suffice
                comp_data[{comp_n[FW-1:0], 3'b000} +: 8] = s_tdata[8*i +: 8];
                comp_n = comp_n + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Merge of residue and stage1
    // ------------------------------------------------------------------
    logic                     out_free;
    logic                     s1_adv;
    logic                     s_hs;
    logic [CW-1:0]            t_w;
    logic [2*DATA_BITS-1:0]   merged;
    logic [LEN_BITS-1:0]      run_total;

    assign out_free = !m_valid_q || m_tready;
    assign s1_adv   = s1_full_q && out_free && (state_q == ACCUM);
    assign s_tready = rst_n && (!s1_full_q || s1_adv);
    assign s_hs     = s_tvalid && s_tready;

    assign t_w       = CW'(f_q) + s1_n_q;
    assign run_total = cnt_q + LEN_BITS'(s1_n_q);

    // Residue and stage1 bytes beyond their counts are kept zero, so a plain
    // OR of the two is enough to append stage1 behind the residue.
    assign merged = {{DATA_BITS{1'b0}}, res_q}
                  | ({{DATA_BITS{1'b0}}, s1_data_q} << {f_q, 3'b000});

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_full_d = s1_full_q;
        s1_data_d = s1_data_q;
        s1_n_d    = s1_n_q;
        s1_last_d = s1_last_q;
        res_d     = res_q;
        f_d       = f_q;
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        cnt_d     = cnt_q;
        plen_d    = plen_q;
        pbytes_d  = pbytes_q;
        pdone_d   = 1'b0;

        // Output handshake; valid is re-asserted below if a new beat loads.
        if (m_valid_q && m_tready) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
                pdone_d  = 1'b1;
                pbytes_d = plen_q;
            end
        end

        if (state_q == FLUSH) begin
            if (out_free) begin
                m_data_d  = res_q;
                m_keep_d  = lo_mask(CW'(f_q));
                m_last_d  = 1'b1;
                m_valid_d = 1'b1;
                res_d     = '0;
                f_d       = '0;
                state_d   = ACCUM;
            end
        end else if (s1_adv) begin
            // Packet length is parked in plen until its tlast beat is taken.
            if (s1_last_q) begin
                plen_d = run_total;
                cnt_d  = '0;
            end else begin
                cnt_d  = run_total;
            end

            if (int'(t_w) >= BYTES) begin
                m_data_d  = merged[DATA_BITS-1:0];
                m_keep_d  = '1;
                m_valid_d = 1'b1;
                res_d     = merged[2*DATA_BITS-1:DATA_BITS];
                f_d       = FW'(t_w - CW'(BYTES));
                m_last_d  = s1_last_q && (t_w == CW'(BYTES));
                if (s1_last_q && (t_w != CW'(BYTES))) begin
                    state_d = FLUSH;
                end
            end else if (s1_last_q) begin
                // Includes t==0: an empty packet still yields a tlast beat.
                m_data_d  = merged[DATA_BITS-1:0];
                m_keep_d  = lo_mask(t_w);
                m_last_d  = 1'b1;
                m_valid_d = 1'b1;
                res_d     = '0;
                f_d       = '0;
            end else begin
                res_d = merged[DATA_BITS-1:0];
                f_d   = FW'(t_w);
            end
        end

        if (s_hs) begin
            s1_full_d = 1'b1;
            s1_data_d = comp_data;
            s1_n_d    = comp_n;
            s1_last_d = s_tlast;
        end else if (s1_adv) begin
            s1_full_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full_q <= 1'b0;
            s1_data_q <= '0;
            s1_n_q    <= '0;
            s1_last_q <= 1'b0;
            res_q     <= '0;
            f_q       <= '0;
            state_q   <= ACCUM;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
            plen_q    <= '0;
            pbytes_q  <= '0;
            pdone_q   <= 1'b0;
        end else begin
            s1_full_q <= s1_full_d;
            s1_data_q <= s1_data_d;
            s1_n_q    <= s1_n_d;
            s1_last_q <= s1_last_d;
            res_q     <= res_d;
            f_q       <= f_d;
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            cnt_q     <= cnt_d;
            plen_q    <= plen_d;
            pbytes_q  <= pbytes_d;
            pdone_q   <= pdone_d;
        end
    end

    assign m_tdata   = m_data_q;
    assign m_tkeep   = m_keep_q;
    assign m_tlast   = m_last_q;
    assign m_tvalid  = m_valid_q;
    assign pkt_bytes = pbytes_q;
    assign pkt_done  = pdone_q;

endmodule

// File: tb/tb_axis_byte_compactor.sv
// Testbench for axis_byte_compactor: a byte-queue reference model feeds a
// scoreboard; a negedge monitor checks every output beat, stall stability
// and the per-packet byte count.
module tb_axis_byte_compactor;

    localparam int DB = 512;
    localparam int NB = 64;
    localparam int LB = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DB-1:0] s_tdata;
    logic [NB-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DB-1:0] m_tdata;
    logic [NB-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [LB-1:0] pkt_bytes;
    logic          pkt_done;

    axis_byte_compactor #(.DATA_BITS(DB), .LEN_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .pkt_bytes(pkt_bytes), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DB-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [LB-1:0] len_q[$];
    logic [7:0]    mq[$];
    logic [LB-1:0] mtotal = '0;
    int            total = 0;
    int            bad = 0;
    logic          bp = 1'b0;

    // Reference: kept bytes form a stream; each 64 bytes is a full beat; the
    // packet end emits whatever remains (possibly nothing) as the tlast beat
    // unless a full beat already ended exactly at the packet end.
    function automatic void model_beat(input logic [DB-1:0] d, input logic [NB-1:0] k,
                                       input logic l);
        beat_t b;
        logic  done_last;
        int    j;
        done_last = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (k[i]) begin
                mq.push_back(d[8*i +: 8]);
                mtotal = mtotal + 1;
            end
        end
        while (mq.size() >= NB) begin
            b.data = '0;
            for (int i = 0; i < NB; i++) b.data[8*i +: 8] = mq.pop_front();
            b.keep = '1;
            b.last = l && (mq.size() == 0);
            if (b.last) done_last = 1'b1;
            exp_q.push_back(b);
        end
        if (l && !done_last) begin
            b.data = '0;
            b.keep = '0;
            j = 0;
            while (mq.size() > 0) begin
                b.data[8*j +: 8] = mq.pop_front();
                b.keep[j] = 1'b1;
                j++;
            end
            b.last = 1'b1;
            exp_q.push_back(b);
        end
        if (l) begin
            len_q.push_back(mtotal);
            mtotal = '0;
        end
    endfunction

    task automatic chk(input string nm, input logic [DB-1:0] got, input logic [DB-1:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", nm, got, need);
        end
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    beat_t         prev;
    beat_t         e;
    logic [DB-1:0] bmask;
    logic [LB-1:0] elen;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev.data || m_tkeep !== prev.keep
                    || m_tlast !== prev.last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b keep=%h last=%0b, held keep=%h last=%0b",
                             m_tvalid, m_tkeep, m_tlast, prev.keep, prev.last);
                end
            end
            if (m_tvalid && m_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got keep=%h last=%0b, need no beat",
                             m_tkeep, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < NB; i++) bmask[8*i +: 8] = {8{e.keep[i]}};
                    if (m_tkeep !== e.keep || m_tlast !== e.last
                        || (m_tdata & bmask) !== (e.data & bmask)) begin
                        bad++;
                        $display("FAIL beat: got keep=%h last=%0b data=%h need keep=%h last=%0b data=%h",
                                 m_tkeep, m_tlast, m_tdata & bmask, e.keep, e.last, e.data & bmask);
                    end
                end
            end
            if (pkt_done) begin
                total++;
                if (len_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pkt_done: got pkt_bytes=%0d, need no pulse", pkt_bytes);
                end else begin
                    elen = len_q.pop_front();
                    if (pkt_bytes !== elen) begin
                        bad++;
                        $display("FAIL pkt_bytes: got %0d need %0d", pkt_bytes, elen);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev.data  = m_tdata;
            prev.keep  = m_tkeep;
            prev.last  = m_tlast;
        end
    end

    always @(posedge clk) begin
        #1;
        m_tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DB-1:0] rand_data();
        logic [DB-1:0] d;
        for (int i = 0; i < DB/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [NB-1:0] rand_keep();
        logic [NB-1:0] k;
        int            mode;
        mode = $urandom_range(0, 4);
        k = {$urandom, $urandom};
        case (mode)
            0: k = k & {$urandom, $urandom};
            1: k = '1;
            2: k = '0;
            3: begin
                k = '0;
                for (int i = 0; i < $urandom_range(1, 63); i++) k[i] = 1'b1;
            end
            default: ;
        endcase
        return k;
    endfunction

    task automatic send_beat(input logic [DB-1:0] d, input logic [NB-1:0] k, input logic l);
        int   waitc;
        logic acc;
        waitc = 0;
        acc = 1'b0;
        s_tdata = d;
        s_tkeep = k;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!acc && waitc < 500) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            waitc++;
        end
        if (acc) begin
            model_beat(d, k, l);
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_tready=0 for %0d cycles, need 1", waitc);
        end
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        idle(3);
        total++;
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats %0d lengths pending, need 0",
                     exp_q.size(), len_q.size());
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int nb;
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", DB'(m_tvalid), '0);
        chk("rst_m_tkeep", DB'(m_tkeep), '0);
        chk("rst_m_tlast", DB'(m_tlast), '0);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_pkt_done", DB'(pkt_done), '0);
        chk("rst_pkt_bytes", DB'(pkt_bytes), '0);
        chk("rst_s_tready", DB'(s_tready), '0);
        rst_n = 1'b1;
        idle(2);

        // dense
        for (int i = 0; i < 3; i++) send_beat(rand_data(), '1, i == 2);
        // holes
        for (int i = 0; i < 4; i++) send_beat(rand_data(), 64'h00FF_00FF_00FF_00FF, i == 3);
        // overflow into flush
        send_beat(rand_data(), 64'h0FFF, 1'b0);
        send_beat(rand_data(), '1, 1'b1);
        // empty packet
        send_beat(rand_data(), '0, 1'b1);
        // full beat then empty last beat
        send_beat(rand_data(), '1, 1'b0);
        send_beat(rand_data(), '0, 1'b1);
        wait_drain();

        // random packets under back-pressure
        bp = 1'b1;
        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                send_beat(rand_data(), rand_keep(), b == nb - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_drain();
        bp = 1'b0;
        idle(2);

        // reset with 20 bytes buffered: nothing may come out
        send_beat(rand_data(), 64'h000F_FFFF, 1'b0);
        idle(4);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        mq.delete();
        mtotal = '0;
        idle(6);
        send_beat(rand_data(), 64'h3FF << 20, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
